// File: rtl/irq_controller.sv
// Seven-level interrupt controller for a 68000 bus.
// Synchronises active-low level requests, applies a CPU-writable mask, and drives the
// highest-priority pending level onto IPL. Answers the CPU's interrupt-acknowledge cycle
// with a per-level IACK strobe (vectoring device), an autovector (VPA) or a bus error
// (spurious acknowledge). Also exposes a small register window (MASK/AVEC/PENDING/STATUS).
//
// Ports:
//   clk, rst            CPU clock, asynchronous active-high reset
//   irq_n[6:0]          active-low requests, bit n-1 = level n
//   as, uds, lds, rw    68000 strobes (active-low) and read/write
//   fc[2:0]             function code, 3'b111 = IACK cycle
//   addr_l[2:0]         A3..A1
//   cs_n                register-window select
//   data_in/data_out    register write/read data, data_oe high while driving
//   ipl[2:0]            active-low encoded level to CPU
//   iack_out_n[6:0]     active-low per-level acknowledge strobes
//   dev_dtack_n         DTACK from the device being acknowledged
//   dtack, vpa, berr    active-low bus responses
module irq_controller #(
  parameter int unsigned NUM_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] irq_n,
  input  logic       as,
  input  logic       uds,
  input  logic       lds,
  input  logic       rw,
  input  logic [2:0] fc,
  input  logic [2:0] addr_l,
  input  logic       cs_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] ipl,
  output logic [6:0] iack_out_n,
  input  logic       dev_dtack_n,
  output logic       dtack,
  output logic       vpa,
  output logic       berr
);

  typedef enum logic [2:0] {
    StIdle,
    StReg,
    StIackDev,
    StIackAuto,
    StIackSpur,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] sync_q [NUM_SYNC];
  logic [7:1] mask_q;
  logic [7:0] avec_q;
  logic [7:0] status_q;
  logic [7:0] rdata_q;
  logic       rd_q;
  logic [2:0] ipl_q;

  logic [7:1] pending;
  logic [7:0] pend8;
  logic [2:0] level;
  logic [1:0] reg_idx;
  logic [7:0] rdata_mux;
  logic       in_iack;
  logic       iack_entry;
  logic       reg_entry;
  logic       reg_write;
  logic       reg_read;
  logic       unused_uds;

  assign unused_uds = uds;

  // Request synchroniser; cleared to the deasserted (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYNC; i++) sync_q[i] <= 7'h7F;
    end else begin
      sync_q[0] <= irq_n;
      for (int i = 1; i < NUM_SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pending = ~sync_q[NUM_SYNC-1] & mask_q;
  assign pend8   = {pending, 1'b0};

  // Priority encoder: highest pending level wins, 0 = none.
  always_comb begin
    level = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (pending[i]) level = 3'(i);
    end
  end

  assign in_iack = (state_q == StIackDev) || (state_q == StIackAuto) ||
                   (state_q == StIackSpur);

  // IPL held during acknowledge so the level being acknowledged cannot move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipl_q <= 3'b111;
    end else if (!in_iack) begin
      ipl_q <= ~level;
    end
  end

  assign ipl = ipl_q;

  assign reg_idx    = addr_l[1:0];
  assign iack_entry = (state_q == StIdle) && !as && (fc == 3'b111);
  assign reg_entry  = (state_q == StIdle) && !as && (fc != 3'b111) && !cs_n;
  assign reg_read   = rw && !lds;
  // Write commits in the first REG cycle only; REG always lasts one cycle.
  assign reg_write  = (state_q == StReg) && !as && !rw && !lds;

  always_comb begin
    rdata_mux = 8'h00;
    unique case (reg_idx)
      2'd0:    rdata_mux = {mask_q, 1'b0};
      2'd1:    rdata_mux = avec_q;
      2'd2:    rdata_mux = pend8;
      default: rdata_mux = status_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      avec_q   <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
    end else begin
      if (reg_write) begin
        case (reg_idx)
          2'd0:    mask_q <= data_in[7:1];
          2'd1:    avec_q <= data_in;
          default: ;
        endcase
      end
      // Read data is captured at entry so the STATUS clear-on-read returns the old flag.
      if (reg_entry) begin
        rd_q    <= reg_read;
        rdata_q <= rdata_mux;
      end
      if (iack_entry) begin
        status_q <= {status_q[7] | ~pend8[addr_l], 4'b0000, addr_l};
      end else if (reg_entry && reg_read && (reg_idx == 2'd3)) begin
        status_q[7] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!as) begin
          if (fc == 3'b111) begin
            if (!pend8[addr_l])     state_d = StIackSpur;
            else if (avec_q[addr_l]) state_d = StIackAuto;
            else                     state_d = StIackDev;
          end else if (!cs_n) begin
            state_d = StReg;
          end
        end
      end
      StReg:                                    state_d = as ? StIdle : StDone;
      StIackDev, StIackAuto, StIackSpur, StDone: if (as) state_d = StIdle;
      default:                                  state_d = StIdle;
    endcase
  end

  always_comb begin
    dtack      = 1'b1;
    vpa        = 1'b1;
    berr       = 1'b1;
    iack_out_n = 7'h7F;
    data_oe    = 1'b0;
    unique case (state_q)
      StReg, StDone: begin
        dtack   = 1'b0;
        data_oe = rd_q;
      end
      StIackDev: begin
        dtack      = dev_dtack_n;
        // Level is 1..7 here; level 0 always routes to the spurious path.
        iack_out_n = ~(7'd1 << (status_q[2:0] - 3'd1));
      end
      StIackAuto: vpa  = 1'b0;
      StIackSpur: berr = 1'b0;
      default: ;
    endcase
  end

  assign data_out = data_oe ? rdata_q : 8'h00;

endmodule

// File: doc/irq_controller.md
# irq_controller

Seven-level interrupt controller sitting directly upstream of the system controller's IPL, VPA and BERR outputs on the Mackerel-10 68000 board. Synchronises up to seven active-low level interrupt requests and applies a CPU-writable mask. Drives the encoded highest-priority pending level onto IPL[2:0]. Services the CPU's interrupt-acknowledge cycle with one of three responses: a per-level IACK strobe for vectoring devices, an autovector (VPA), or a bus error for spurious acknowledges.

## Interface
- NUM_SYNC, default 2: synchroniser depth for IRQ inputs (≥2).
- CLK  in  1  CPU clock (CLK_CPU domain); all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IRQ_N  in  7  active-low level requests; bit n-1 = level n (level 7 highest).
- AS, UDS, LDS, RW  in  1 each  68000 bus strobes (active-low), read/write.
- FC  in  3  CPU function code; 3'b111 = IACK cycle.
- ADDR_L  in  3  CPU A3..A1.
- CS_N  in  1  active-low register-window select from the address decoder.
- DATA_IN  in  8  D7..D0 from CPU.
- DATA_OUT  out  8  register read data; DATA_OE  out  1  high while driving.
- IPL  out  3  active-low encoded level to CPU (3'b111 = none).
- IACK_OUT_N  out  7  active-low per-level acknowledge strobes to devices.
- DEV_DTACK_N  in  1  DTACK from the vectoring device being acknowledged.
- DTACK, VPA, BERR  out  1 each  active-low bus responses.

## Operation
- Each IRQ_N bit is passed through NUM_SYNC flops. Result: req[7:1] = ~synced.
- pending[7:1] = req & MASK[7:1]. The encoder picks the highest set bit, 1..7; IPL = ~level, registered.
- IPL is frozen while the FSM is in any IACK state, so the acknowledged level cannot change mid-cycle.
- Registers are accessed only with LDS low. Register index = ADDR_L[2:1]:
  - 0: MASK, R/W, bit0 reads 0.
  - 1: AVEC, R/W, bit n = 1 means autovector level n.
  - 2: PENDING, RO.
  - 3: STATUS, RO; bits[2:0] = last acknowledged level, bit7 = spurious-seen flag. Reading STATUS clears bit7.
  - Writes to indexes 2 and 3 are ignored but still acknowledged.
- FSM states: IDLE, REG, IACK_DEV, IACK_AUTO, IACK_SPUR, DONE.
- IDLE transitions, evaluated with AS low:
  - CS_N low and FC != 7 → REG. A write, if any, commits once, in the entry cycle.
  - FC == 7 with lvl = ADDR_L[3:1]:
    - pending[lvl] = 0 → IACK_SPUR.
    - AVEC[lvl] = 1 → IACK_AUTO.
    - otherwise → IACK_DEV.
  - Entering any IACK state latches lvl into STATUS[2:0]. Entering IACK_SPUR also sets STATUS[7].
- REG: DTACK low; for reads, DATA_OE high and DATA_OUT = register. REG → DONE.
- IACK_DEV: IACK_OUT_N[lvl-1] low. DTACK mirrors DEV_DTACK_N. Stays until AS high → IDLE.
- IACK_AUTO: VPA low until AS high → IDLE.
- IACK_SPUR: BERR low until AS high → IDLE.
- DONE: holds DTACK low and DATA_OE until AS high, then → IDLE.
- The controller does not clear interrupts; each device clears its own request by deasserting its IRQ_N.
- AS rising in any state forces IDLE on the next edge and releases every strobe in that same edge.
- Reset, at any time including mid-cycle:
  - MASK = 0, AVEC = 0, STATUS = 0, state = IDLE.
  - IPL = 3'b111; DTACK, VPA, BERR = 1; IACK_OUT_N = 7'h7F.
  - DATA_OE = 0, DATA_OUT = 0; sync flops cleared to the deasserted level.

## Timing
- IRQ_N falling to IPL change is NUM_SYNC+1 cycles: 3 cycles at the default depth.
- A MASK write takes effect on IPL 2 cycles after FSM entry: 1 cycle register commit + 1 cycle IPL register.
- Register access: DTACK falls on the first edge after AS and CS_N are both sampled low, and rises 1 cycle after AS is sampled high.
- IACK responses (IACK_OUT_N, VPA, BERR) assert 1 cycle after AS is sampled low and release 1 cycle after AS is sampled high.
- When a request drops between IPL assertion and the IACK cycle, the acknowledge is treated as spurious (BERR). No priority inversion to a lower level is possible.
- Back-to-back bus cycles require AS high for at least 1 sampled edge; the FSM always passes through IDLE.

## Test plan
- Reset state: assert RST mid-REG → all outputs at reset values within 0 cycles of assertion (async); MASK reads 0x00 after release.
- Priority: MASK = 0xFE, IRQ_N = 7'b1101011 (levels 3 and 5) → IPL = 3'b010 after 3 cycles. Release level 5 → IPL = 3'b100.
- Masking: MASK = 0x08 (level 3 only), assert level 6 → IPL stays 3'b111. Write MASK = 0x40 → IPL = 3'b001 2 cycles after the write cycle's FSM entry.
- Autovector: AVEC = 0x20, level 5 pending, IACK cycle with ADDR_L = 3'b101 → VPA low 1 cycle after AS low, STATUS = 0x05, IACK_OUT_N stays 7'h7F.
- Vectored: AVEC = 0, level 2 pending, IACK with ADDR_L = 3'b010 → IACK_OUT_N = 7'b1111101. DTACK tracks DEV_DTACK_N; all release 1 cycle after AS high.
- Spurious: no pending, IACK at level 4 → BERR low and STATUS = 0x84. Reading STATUS returns 0x84, then 0x04.
